// File: rtl/sign_extender_pkg.sv
// Shared definitions for the pierogi immediate-extension unit: mode encoding
// and default datapath widths.
package sign_extender_pkg;

    typedef enum logic [1:0] {
        MODE_SIGN   = 2'b00,
        MODE_ZERO   = 2'b01,
        MODE_UPPER  = 2'b10,
        MODE_BRANCH = 2'b11
    } mode_t;

    localparam int IMM_W  = 16;
    localparam int WORD_W = 32;

endpackage : sign_extender_pkg

// File: rtl/sign_extender_core.sv
// Combinational immediate extension: sign, zero, upper-load and branch-offset
// forms of an IN_WIDTH immediate widened to OUT_WIDTH.
module sign_extender_core
    import sign_extender_pkg::*;
#(
    parameter int IN_WIDTH  = IMM_W,
    parameter int OUT_WIDTH = WORD_W,
    parameter int BR_SHIFT  = 2
) (
    input  logic [IN_WIDTH-1:0]  immediate,
    input  logic [1:0]           mode,
    output logic [OUT_WIDTH-1:0] result
);

    logic [OUT_WIDTH-1:0] sign_s;
    logic [OUT_WIDTH-1:0] zero_s;
    logic [OUT_WIDTH-1:0] upper_s;

    // Build each candidate by overlaying the immediate on a filled word, which
    // stays legal when OUT_WIDTH equals IN_WIDTH.
    always_comb begin
        sign_s                     = {OUT_WIDTH{immediate[IN_WIDTH-1]}};
        sign_s[IN_WIDTH-1:0]       = immediate;
        zero_s                     = '0;
        zero_s[IN_WIDTH-1:0]       = immediate;
        upper_s                    = '0;
        upper_s[OUT_WIDTH-1 -: IN_WIDTH] = immediate;
    end

    // Select the form requested by the mode field.
    always_comb begin
        result = '0;
        case (mode_t'(mode))
            MODE_SIGN:   result = sign_s;
            MODE_ZERO:   result = zero_s;
            MODE_UPPER:  result = upper_s;
            MODE_BRANCH: result = sign_s << BR_SHIFT;
            default:     result = '0;
        endcase
    end

endmodule : sign_extender_core

// File: rtl/sign_extender.sv
// Registered immediate-extension unit with a valid flag and one cycle latency.
// Optional macro SIGN_EXTENDER_COMB_OUT_EN adds the unregistered result port.
module sign_extender
    import sign_extender_pkg::*;
#(
    parameter int IN_WIDTH  = IMM_W,
    parameter int OUT_WIDTH = WORD_W,
    parameter int BR_SHIFT  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [IN_WIDTH-1:0]  immediate,
    input  logic [1:0]           mode,
    input  logic                 in_valid,
`ifdef SIGN_EXTENDER_COMB_OUT_EN
    output logic [OUT_WIDTH-1:0] extended_immediate_comb,
`endif
    output logic [OUT_WIDTH-1:0] extended_immediate,
    output logic                 out_valid
);

    logic [OUT_WIDTH-1:0] core_result_s;
    logic [OUT_WIDTH-1:0] ext_r;
    logic                 valid_r;

    sign_extender_core #(
        .IN_WIDTH  (IN_WIDTH),
        .OUT_WIDTH (OUT_WIDTH),
        .BR_SHIFT  (BR_SHIFT)
    ) u_core (
        .immediate (immediate),
        .mode      (mode),
        .result    (core_result_s)
    );

    // Capture qualified results; the data holds when no new input arrives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ext_r   <= '0;
            valid_r <= 1'b0;
        end else begin
            valid_r <= in_valid;
            if (in_valid) begin
                ext_r <= core_result_s;
            end else begin
                ext_r <= ext_r;
            end
        end
    end

    assign extended_immediate = ext_r;
    assign out_valid          = valid_r;

`ifdef SIGN_EXTENDER_COMB_OUT_EN
    assign extended_immediate_comb = core_result_s;
`endif

endmodule : sign_extender

// File: tb/tb_sign_extender.sv
// Self-checking bench for sign_extender: directed vectors, randomized traffic
// against an arithmetic reference model, and asynchronous reset behaviour.
module tb_sign_extender;

    logic        clk;
    logic        rst;
    logic [15:0] immediate;
    logic [1:0]  mode;
    logic        in_valid;
    logic [31:0] extended_immediate;
    logic        out_valid;
`ifdef SIGN_EXTENDER_COMB_OUT_EN
    logic [31:0] extended_immediate_comb;
`endif

    int checks;
    int passed;

    logic [31:0] exp_data;
    logic        exp_valid;

    sign_extender dut (
        .clk                     (clk),
        .rst                     (rst),
        .immediate               (immediate),
        .mode                    (mode),
        .in_valid                (in_valid),
`ifdef SIGN_EXTENDER_COMB_OUT_EN
        .extended_immediate_comb (extended_immediate_comb),
`endif
        .extended_immediate      (extended_immediate),
        .out_valid               (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: interpret the immediate as an integer and do the arithmetic.
    function automatic logic [31:0] ref_ext(input logic [15:0] imm, input logic [1:0] m);
        longint s;
        longint r;
        s = (imm >= 16'h8000) ? longint'(imm) - 64'sd65536 : longint'(imm);
        case (m)
            2'd0:    r = s;
            2'd1:    r = longint'(imm);
            2'd2:    r = longint'(imm) * 64'sd65536;
            default: r = s * 64'sd4;
        endcase
        return r[31:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) begin
            passed++;
        end else begin
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, " data"}, extended_immediate, exp_data);
        check({tag, " valid"}, {31'd0, out_valid}, {31'd0, exp_valid});
    endtask

    // Drive one cycle, update the model, sample just after the edge.
    task automatic step(input logic [15:0] imm, input logic [1:0] m, input logic v, input string tag);
        @(negedge clk);
        immediate = imm;
        mode      = m;
        in_valid  = v;
        @(posedge clk);
        if (v) exp_data = ref_ext(imm, m);
        exp_valid = v;
        #1;
        check_outputs(tag);
    endtask

    initial begin
        checks    = 0;
        passed    = 0;
        rst       = 1'b1;
        immediate = 16'h8000;
        mode      = 2'b00;
        in_valid  = 1'b1;
        exp_data  = 32'd0;
        exp_valid = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset");
`ifdef SIGN_EXTENDER_COMB_OUT_EN
        check("comb in reset", extended_immediate_comb, 32'hFFFF8000);
`endif
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;

        // Directed boundary vectors with fixed expected values.
        step(16'h000A, 2'b00, 1'b1, "sign 000A");
        check("k sign 000A", extended_immediate, 32'h0000000A);
        step(16'hFFFA, 2'b00, 1'b1, "sign FFFA");
        check("k sign FFFA", extended_immediate, 32'hFFFFFFFA);
        step(16'h7FFF, 2'b00, 1'b1, "sign 7FFF");
        check("k sign 7FFF", extended_immediate, 32'h00007FFF);
        step(16'h8000, 2'b00, 1'b1, "sign 8000");
        check("k sign 8000", extended_immediate, 32'hFFFF8000);
`ifdef SIGN_EXTENDER_COMB_OUT_EN
        #1;
        check("comb sign 8000", extended_immediate_comb, 32'hFFFF8000);
`endif
        step(16'h8000, 2'b01, 1'b1, "zero 8000");
        check("k zero 8000", extended_immediate, 32'h00008000);
        step(16'hFFFF, 2'b01, 1'b1, "zero FFFF");
        check("k zero FFFF", extended_immediate, 32'h0000FFFF);
        step(16'h1234, 2'b10, 1'b1, "upper 1234");
        check("k upper 1234", extended_immediate, 32'h12340000);
        step(16'hFFFF, 2'b11, 1'b1, "branch FFFF");
        check("k branch FFFF", extended_immediate, 32'hFFFFFFFC);
        step(16'h4000, 2'b11, 1'b1, "branch 4000");
        check("k branch 4000", extended_immediate, 32'h00010000);
        for (int m = 0; m < 4; m++) begin
            step(16'h0000, 2'(m), 1'b1, "zero imm");
            check("k zero imm", extended_immediate, 32'd0);
        end

        // Back-to-back with alternating modes, then idle holds the last value.
        step(16'h9ABC, 2'b00, 1'b1, "b2b 0");
        step(16'h9ABC, 2'b01, 1'b1, "b2b 1");
        step(16'h9ABC, 2'b10, 1'b1, "b2b 2");
        step(16'h9ABC, 2'b11, 1'b1, "b2b 3");
        check("k b2b last", extended_immediate, 32'hFFFE6AF0);
        step(16'h1111, 2'b00, 1'b0, "idle hold");
        check("k idle hold", extended_immediate, 32'hFFFE6AF0);

        // Randomized traffic against the model.
        for (int i = 0; i < 60; i++) begin
            step(16'($urandom), 2'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0), "random");
        end

        // Asynchronous reset between edges drops the held result at once.
        step(16'hFFFA, 2'b00, 1'b1, "pre-reset");
        #3;
        rst = 1'b1;
        #1;
        exp_data  = 32'd0;
        exp_valid = 1'b0;
        check_outputs("async reset");
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        check_outputs("valid under reset");
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        step(16'h5555, 2'b00, 1'b0, "post-release idle 0");
        step(16'h5555, 2'b01, 1'b0, "post-release idle 1");
        step(16'h0123, 2'b11, 1'b1, "first after reset");
        check("k first after reset", extended_immediate, 32'h0000048C);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule : tb_sign_extender
